npx_serial_core_scheduler: RTL

- Round-robin scheduler that shares one bit-serial spike×weight core (one-hot counter based) among NUM_REQ requesters.
- Accepts one job at a time: a spike word plus a weight word. It loads the job into the core with a one-cycle init pulse, then waits for the core's finish pulse.
- Returns a completion record to the requester: id, error flag and elapsed cycles.
- Sits between the NPX layer sequencers and the serial core. It owns the core's init and clear controls.

---
 rtl/npx_serial_core_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/npx_serial_core_scheduler.sv
// Round-robin scheduler sharing one bit-serial spike x weight core among NUM_REQ
// requesters: grants one job, drives the core's init/clear, returns a completion record.
module npx_serial_core_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int SPIKE_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAX_CYCLES   = 1000,
    parameter int CYCLE_WIDTH  = 16,
    parameter int ID_WIDTH     = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*SPIKE_WIDTH-1:0]  req_spike,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] req_weight,
    output logic                            core_init,
    output logic                            core_clear,
    output logic [SPIKE_WIDTH-1:0]          core_spike,
    output logic [WEIGHT_WIDTH-1:0]         core_weight,
    input  logic                            core_finish,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic                            rsp_error,
    output logic [CYCLE_WIDTH-1:0]          rsp_cycles,
    output logic                            busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PTR_W-1:0]        r_rr_ptr;
    logic [PTR_W-1:0]        w_rr_ptr_nxt;
    logic [CYCLE_WIDTH-1:0]  r_cnt;
    logic [CYCLE_WIDTH-1:0]  w_cnt_nxt;
    logic [SPIKE_WIDTH-1:0]  r_core_spike;
    logic [SPIKE_WIDTH-1:0]  w_core_spike_nxt;
    logic [WEIGHT_WIDTH-1:0] r_core_weight;
    logic [WEIGHT_WIDTH-1:0] w_core_weight_nxt;
    logic [ID_WIDTH-1:0]     r_rsp_id;
    logic [ID_WIDTH-1:0]     w_rsp_id_nxt;
    logic                    r_rsp_error;
    logic                    w_rsp_error_nxt;
    logic [CYCLE_WIDTH-1:0]  r_rsp_cycles;
    logic [CYCLE_WIDTH-1:0]  w_rsp_cycles_nxt;
    logic                    w_core_init;
    logic                    w_core_clear;

    logic                    w_grant_found;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [NUM_REQ-1:0]      w_grant_oh;
    logic [SPIKE_WIDTH-1:0]  w_sel_spike;
    logic [WEIGHT_WIDTH-1:0] w_sel_weight;

    // Round-robin pick: hits are overwritten by lower indices, so the wrapped range
    // is scanned first and the range starting at rr_ptr last (it takes priority).
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_sel_spike   = '0;
        w_sel_weight  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(r_rr_ptr))) begin
                w_grant_found = 1'b1;
                w_grant_idx   = PTR_W'(i);
                w_sel_spike   = req_spike[i*SPIKE_WIDTH +: SPIKE_WIDTH];
                w_sel_weight  = req_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end else begin
                w_grant_found = w_grant_found;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(r_rr_ptr))) begin
                w_grant_found = 1'b1;
                w_grant_idx   = PTR_W'(i);
                w_sel_spike   = req_spike[i*SPIKE_WIDTH +: SPIKE_WIDTH];
                w_sel_weight  = req_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end else begin
                w_grant_found = w_grant_found;
            end
        end
    end

    assign w_grant_oh = w_grant_found ? (NUM_REQ'(1'b1) << w_grant_idx) : '0;

    // Next-state and datapath updates; the register block applies them only when enabled.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_cnt_nxt         = r_cnt;
        w_core_spike_nxt  = r_core_spike;
        w_core_weight_nxt = r_core_weight;
        w_rsp_id_nxt      = r_rsp_id;
        w_rsp_error_nxt   = r_rsp_error;
        w_rsp_cycles_nxt  = r_rsp_cycles;
        w_core_init       = 1'b0;
        w_core_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_core_spike_nxt  = w_sel_spike;
                    w_core_weight_nxt = w_sel_weight;
                    w_rsp_id_nxt      = ID_WIDTH'(w_grant_idx);
                    if (w_sel_spike != '0) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        // Zero spike word yields a zero product: answer without the core.
                        w_state_nxt      = ST_RESP;
                        w_rsp_error_nxt  = 1'b0;
                        w_rsp_cycles_nxt = '0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_core_init = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (core_finish) begin
                    w_state_nxt      = ST_RESP;
                    w_rsp_error_nxt  = 1'b0;
                    w_rsp_cycles_nxt = r_cnt + CYCLE_WIDTH'(1);
                end else if (r_cnt == CYCLE_WIDTH'(MAX_CYCLES - 1)) begin
                    w_core_clear     = 1'b1;
                    w_state_nxt      = ST_RESP;
                    w_rsp_error_nxt  = 1'b1;
                    w_rsp_cycles_nxt = CYCLE_WIDTH'(MAX_CYCLES);
                end else begin
                    w_cnt_nxt = r_cnt + CYCLE_WIDTH'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                    if (r_rsp_id >= ID_WIDTH'(NUM_REQ - 1)) begin
                        w_rr_ptr_nxt = '0;
                    end else begin
                        w_rr_ptr_nxt = PTR_W'(r_rsp_id) + PTR_W'(1);
                    end
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; enable=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_core_spike  <= '0;
            r_core_weight <= '0;
            r_rsp_id      <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_cycles  <= '0;
        end else if (enable) begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_core_spike  <= w_core_spike_nxt;
            r_core_weight <= w_core_weight_nxt;
            r_rsp_id      <= w_rsp_id_nxt;
            r_rsp_error   <= w_rsp_error_nxt;
            r_rsp_cycles  <= w_rsp_cycles_nxt;
        end
    end

    assign req_ready   = ((r_state == ST_IDLE) && enable && !rst) ? w_grant_oh : '0;
    assign core_init   = w_core_init  && enable && !rst;
    assign core_clear  = w_core_clear && enable && !rst;
    assign core_spike  = r_core_spike;
    assign core_weight = r_core_weight;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_id      = r_rsp_id;
    assign rsp_error   = r_rsp_error;
    assign rsp_cycles  = r_rsp_cycles;
    assign busy        = (r_state != ST_IDLE);

endmodule
